lookup_em: RTL

LOOKUP_EM -- requirements
Module: lookup_em

---
 rtl/lookup_em.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lookup_em.sv
// Exact-match lookup engine. Keys are buffered in a 16-deep FIFO and compared
// against a 16-entry table. Each key yields one index, in arrival order. The
// table is loaded and the counters are read over a simple localbus.
module lookup_em #(
    parameter logic [15:0] MISS_INDEX = 16'h1FFF,
    parameter logic [4:0]  ALF_TH     = 5'd12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_key_wr,
    input  logic [511:0] in_key,
    output logic         out_key_alf,
    output logic         out_index_wr,
    output logic [15:0]  out_index,
    input  logic         in_index_alf,
    input  logic         cfg_cs_n,
    input  logic         cfg_rw,
    input  logic [31:0]  cfg_addr,
    input  logic [31:0]  cfg_wdata,
    output logic         cfg_ack_n,
    output logic [31:0]  cfg_rdata
);
    typedef enum logic [1:0] {LK_IDLE = 2'd0, LK_CMP = 2'd1, LK_OUT = 2'd2} lk_state_t;
    typedef enum logic [2:0] {CF_IDLE, CF_WRITE, CF_READ, CF_WAIT, CF_ACK} cf_state_t;

    logic [511:0] fifo_mem [16];
    logic [3:0]   wr_ptr, rd_ptr;
    logic [4:0]   fifo_cnt;
    logic         fifo_full, fifo_empty, push, pop;

    lk_state_t    lk_state, lk_next;
    logic [511:0] key_reg;
    logic [511:0] tbl_key [16];
    logic [15:0]  tbl_vld;
    logic         match_hit;
    logic [3:0]   match_idx;
    logic [31:0]  key_in_cnt, hit_cnt, miss_cnt, drop_cnt;

    cf_state_t    cf_state, cf_next;
    logic         cs_s1, cs_s2, sel;
    logic [511:0] stage;
    logic [7:0]   word;
    logic [31:0]  rd_mux, rd_hold;
    logic         addr_unused;

    assign fifo_full   = (fifo_cnt == 5'd16);
    assign fifo_empty  = (fifo_cnt == 5'd0);
    assign out_key_alf = (fifo_cnt >= ALF_TH);
    // Only the start of a lookup is gated by downstream backpressure.
    assign pop  = (lk_state == LK_IDLE) && !fifo_empty && !in_index_alf;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = in_key_wr && (!fifo_full || pop);

    assign sel         = !cs_s2;
    assign word        = cfg_addr[9:2];
    assign addr_unused = ^{cfg_addr[31:10], cfg_addr[1:0]};

    // FIFO storage; occupancy is tracked by the pointers, so no reset needed
    always_ff @(posedge clk)
        if (push) fifo_mem[wr_ptr] <= in_key;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= 4'd0;
            rd_ptr   <= 4'd0;
            fifo_cnt <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
            fifo_cnt <= fifo_cnt + {4'd0, push} - {4'd0, pop};
        end

    // Lookup FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lk_state <= LK_IDLE;
        else        lk_state <= lk_next;

    // Lookup FSM next state
    always_comb begin
        lk_next = lk_state;
        case (lk_state)
            LK_IDLE: if (pop) lk_next = LK_CMP;
            LK_CMP:  lk_next = LK_OUT;
            LK_OUT:  lk_next = LK_IDLE;
            default: lk_next = LK_IDLE;
        endcase
    end

    // Parallel compare; scanning downward leaves the lowest matching entry
    always_comb begin
        match_hit = 1'b0;
        match_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (tbl_vld[i] && tbl_key[i] == key_reg) begin
                match_hit = 1'b1;
                match_idx = 4'(i);
            end
    end

    // Key capture, result register and statistics counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            key_reg      <= '0;
            out_index_wr <= 1'b0;
            out_index    <= 16'd0;
            key_in_cnt   <= 32'd0;
            hit_cnt      <= 32'd0;
            miss_cnt     <= 32'd0;
            drop_cnt     <= 32'd0;
        end else begin
            if (pop) key_reg <= fifo_mem[rd_ptr];
            out_index_wr <= (lk_state == LK_CMP);
            if (lk_state == LK_CMP) begin
                out_index <= match_hit ? {12'h000, match_idx} : MISS_INDEX;
                if (match_hit) hit_cnt  <= hit_cnt + 32'd1;
                else           miss_cnt <= miss_cnt + 32'd1;
            end
            if (push)                   key_in_cnt <= key_in_cnt + 32'd1;
            if (in_key_wr && !push)     drop_cnt   <= drop_cnt + 32'd1;
        end

    // Table keys; only meaningful behind their valid bit, so no reset needed
    always_ff @(posedge clk)
        if (cf_state == CF_WRITE && word == 8'h10) tbl_key[cfg_wdata[3:0]] <= stage;

    // Chip-select synchroniser and cfg FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cf_state <= CF_IDLE;
        end else begin
            cs_s1    <= cfg_cs_n;
            cs_s2    <= cs_s1;
            cf_state <= cf_next;
        end

    // Cfg FSM next state
    always_comb begin
        cf_next = cf_state;
        case (cf_state)
            CF_IDLE:  if (sel && cfg_ack_n) cf_next = cfg_rw ? CF_READ : CF_WRITE;
            CF_WRITE: cf_next = CF_ACK;
            CF_READ:  cf_next = CF_WAIT;
            CF_WAIT:  cf_next = CF_ACK;
            CF_ACK:   if (!sel) cf_next = CF_IDLE;
            default:  cf_next = CF_IDLE;
        endcase
    end

    // Read word mux
    always_comb begin
        rd_mux = 32'd0;
        if (word < 8'h10) rd_mux = stage[{word[3:0], 5'd0} +: 32];
        else begin
            case (word)
                8'h11:   rd_mux = key_in_cnt;
                8'h12:   rd_mux = hit_cnt;
                8'h13:   rd_mux = miss_cnt;
                8'h14:   rd_mux = drop_cnt;
                8'h15:   rd_mux = {lk_state, 25'd0, fifo_cnt};
                default: rd_mux = 32'd0;
            endcase
        end
    end

    // Cfg side effects, read capture and the ack handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stage     <= '0;
            tbl_vld   <= 16'd0;
            rd_hold   <= 32'd0;
            cfg_ack_n <= 1'b1;
            cfg_rdata <= 32'd0;
        end else begin
            if (cf_state == CF_WRITE) begin
                if (word < 8'h10)       stage[{word[3:0], 5'd0} +: 32] <= cfg_wdata;
                else if (word == 8'h10) tbl_vld[cfg_wdata[3:0]] <= cfg_wdata[8];
                rd_hold <= 32'd0;
            end
            if (cf_state == CF_READ) rd_hold <= rd_mux;
            if (cf_state == CF_ACK) begin
                if (sel) begin
                    cfg_ack_n <= 1'b0;
                    cfg_rdata <= rd_hold;
                end else begin
                    cfg_ack_n <= 1'b1;
                    cfg_rdata <= 32'd0;
                end
            end
        end
endmodule
